// File: rtl/sprite_addr_cal_if.sv
// Sprite address generator bus: descriptor, sprite state and beam position
// going in, texel address and hit flag coming out.
interface sprite_addr_cal_if;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  // Display block side: supplies descriptor/beam, consumes the result.
  modport master (
    output pattern_info,
    output sprite_info,
    output hcount,
    output vcount,
    input  addr_output,
    input  valid
  );

  // Address generator side.
  modport slave (
    input  pattern_info,
    input  sprite_info,
    input  hcount,
    input  vcount,
    output addr_output,
    output valid
  );
endinterface

// File: rtl/sprite_addr_cal.sv
// Per-sprite texel address generator. Decides each pixel whether the beam
// lies on a drawable texel of the sprite and, if so, the pixel-memory word
// address of that texel. One-cycle latency, one result per clock.
module sprite_addr_cal (
  input  logic                 clk,
  input  logic                 reset,
  sprite_addr_cal_if.slave     bus
);

  // True when start <= pos < start + len. Widened to 17 bits so that the
  // box end never wraps past the 10-bit screen coordinate range.
  function automatic logic in_span(input logic [9:0] pos,
                                   input logic [9:0] start,
                                   input logic [15:0] len);
    logic [16:0] pos_w;
    logic [16:0] end_w;
    pos_w = {7'd0, pos};
    end_w = {7'd0, start} + {1'b0, len};
    in_span = (pos >= start) && (pos_w < end_w);
  endfunction

  // Column inside the stored image, mirrored when the sprite faces left.
  function automatic logic [15:0] texel_col(input logic        flip,
                                            input logic [15:0] width,
                                            input logic [15:0] col);
    if (flip) begin
      texel_col = width - 16'd1 - col;
    end else begin
      texel_col = col;
    end
  endfunction

  // Field split of the descriptor and sprite state words.
  logic [15:0] base_s;
  logic [15:0] img_w_s;
  logic [15:0] img_h_s;
  logic [15:0] draw_w_s;
  logic [15:0] draw_h_s;
  logic        visible_s;
  logic        hflip_s;
  logic [9:0]  x_s;
  logic [9:0]  y_s;

  assign base_s    = bus.pattern_info[79:64];
  assign img_w_s   = bus.pattern_info[63:48];
  assign img_h_s   = bus.pattern_info[47:32];
  assign draw_w_s  = bus.pattern_info[31:16];
  assign draw_h_s  = bus.pattern_info[15:0];
  assign visible_s = bus.sprite_info[31];
  assign hflip_s   = bus.sprite_info[30];
  assign x_s       = bus.sprite_info[29:20];
  assign y_s       = bus.sprite_info[19:10];

  // Intermediates for the current beam sample.
  logic [9:0]  col_s;
  logic [9:0]  row_s;
  logic [15:0] col_w_s;
  logic [15:0] row_w_s;
  logic        in_box_s;
  logic        in_img_s;
  logic        hit_s;
  logic [15:0] tcol_s;
  logic [31:0] prod_s;
  logic [15:0] addr_s;

  // Output registers.
  logic        valid_r;
  logic [15:0] addr_r;

  // Reserved sprite bits and the upper product half are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{bus.sprite_info[9:0], prod_s[31:16]};

  // Hit detection and texel address arithmetic for the current sample.
  always_comb begin
    col_s    = bus.hcount - x_s;
    row_s    = bus.vcount - y_s;
    col_w_s  = {6'd0, col_s};
    row_w_s  = {6'd0, row_s};
    in_box_s = 1'b0;
    in_img_s = 1'b0;
    if (visible_s) begin
      in_box_s = in_span(bus.hcount, x_s, draw_w_s) &&
                 in_span(bus.vcount, y_s, draw_h_s);
    end else begin
      in_box_s = 1'b0;
    end
    // Guards against a draw box larger than the stored image; also
    // rejects img_w == 0 so the mirror below never underflows into a hit.
    in_img_s = (col_w_s < img_w_s) && (row_w_s < img_h_s);
    hit_s    = in_box_s && in_img_s;
    tcol_s   = texel_col(hflip_s, img_w_s, col_w_s);
    prod_s   = {16'd0, row_w_s} * {16'd0, img_w_s};
    addr_s   = base_s + prod_s[15:0] + tcol_s;
  end

  // Register the result; the address is forced to zero on a miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      addr_r  <= 16'd0;
    end else begin
      valid_r <= hit_s;
      addr_r  <= hit_s ? addr_s : 16'd0;
    end
  end

  assign bus.valid       = valid_r;
  assign bus.addr_output = addr_r;

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed bench for sprite_addr_cal: a table of single-sample vectors plus
// hand-written reset, visibility sweep and latency sequences.
module tb_sprite_addr_cal;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  sprite_addr_cal_if bus ();

  sprite_addr_cal dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] pat;
    logic [31:0] spr;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        ev;
    logic [15:0] ea;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [79:0] mk_pat(input logic [15:0] base, input logic [15:0] iw,
                                         input logic [15:0] ih, input logic [15:0] dw,
                                         input logic [15:0] dh);
    mk_pat = {base, iw, ih, dw, dh};
  endfunction

  function automatic logic [31:0] mk_spr(input logic vis, input logic flip,
                                         input logic [9:0] x, input logic [9:0] y);
    mk_spr = {vis, flip, x, y, 10'd0};
  endfunction

  task automatic chk(input string nm, input logic ev, input logic [15:0] ea);
    checks++;
    if (bus.valid !== ev || bus.addr_output !== ea) begin
      errors++;
      $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
               nm, bus.valid, bus.addr_output, ev, ea);
    end
  endtask

  task automatic drive(input logic [79:0] p, input logic [31:0] s,
                       input logic [9:0] h, input logic [9:0] v);
    bus.pattern_info = p;
    bus.sprite_info  = s;
    bus.hcount       = h;
    bus.vcount       = v;
  endtask

  initial begin
    logic [79:0] p0;
    logic [79:0] p1;
    logic [31:0] s0;
    logic [31:0] sf;
    errors = 0;
    checks = 0;
    p0 = mk_pat(16'd0, 16'd16, 16'd16, 16'd16, 16'd16);
    p1 = mk_pat(16'd256, 16'd16, 16'd8, 16'd16, 16'd8);
    s0 = mk_spr(1'b1, 1'b0, 10'd100, 10'd50);
    sf = mk_spr(1'b1, 1'b1, 10'd100, 10'd50);

    // Reset state
    reset = 1'b1;
    drive(p0, s0, 10'd100, 10'd50);
    @(posedge clk); #1;
    chk("reset_hold", 1'b0, 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("first_after_reset", 1'b1, 16'd0);

    // Vector table
    vecs.push_back('{p0, s0, 10'd100, 10'd50, 1'b1, 16'd0});
    vecs.push_back('{p0, s0, 10'd115, 10'd50, 1'b1, 16'd15});
    vecs.push_back('{p0, s0, 10'd103, 10'd52, 1'b1, 16'd35});
    vecs.push_back('{p0, s0, 10'd116, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{p0, s0, 10'd99,  10'd50, 1'b0, 16'd0});
    vecs.push_back('{p0, s0, 10'd100, 10'd66, 1'b0, 16'd0});
    vecs.push_back('{p0, s0, 10'd100, 10'd65, 1'b1, 16'd240});
    vecs.push_back('{p0, s0, 10'd100, 10'd49, 1'b0, 16'd0});
    vecs.push_back('{p1, mk_spr(1'b1, 1'b0, 10'd0, 10'd0), 10'd5, 10'd7, 1'b1, 16'd373});
    vecs.push_back('{p1, mk_spr(1'b1, 1'b0, 10'd0, 10'd0), 10'd5, 10'd8, 1'b0, 16'd0});
    vecs.push_back('{p0, sf, 10'd100, 10'd50, 1'b1, 16'd15});
    vecs.push_back('{p0, sf, 10'd115, 10'd51, 1'b1, 16'd16});
    vecs.push_back('{mk_pat(16'd0, 16'd20, 16'd16, 16'd16, 16'd16), sf, 10'd100, 10'd50, 1'b1, 16'd19});
    // draw_w / draw_h / img_w zero
    vecs.push_back('{mk_pat(16'd0, 16'd16, 16'd16, 16'd0, 16'd16), s0, 10'd100, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{mk_pat(16'd0, 16'd16, 16'd16, 16'd16, 16'd0), s0, 10'd100, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{mk_pat(16'd0, 16'd0, 16'd16, 16'd16, 16'd16), s0, 10'd100, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{mk_pat(16'd0, 16'd0, 16'd16, 16'd16, 16'd16), sf, 10'd100, 10'd50, 1'b0, 16'd0});
    // draw box larger than image
    vecs.push_back('{mk_pat(16'd0, 16'd4, 16'd4, 16'd16, 16'd16), s0, 10'd104, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{mk_pat(16'd0, 16'd4, 16'd4, 16'd16, 16'd16), s0, 10'd103, 10'd54, 1'b0, 16'd0});
    vecs.push_back('{mk_pat(16'd0, 16'd4, 16'd4, 16'd16, 16'd16), s0, 10'd103, 10'd53, 1'b1, 16'd15});
    // right screen edge, no wrap to column 0
    vecs.push_back('{p0, mk_spr(1'b1, 1'b0, 10'd630, 10'd50), 10'd639, 10'd50, 1'b1, 16'd9});
    vecs.push_back('{p0, mk_spr(1'b1, 1'b0, 10'd1020, 10'd50), 10'd2, 10'd50, 1'b0, 16'd0});
    vecs.push_back('{p0, mk_spr(1'b1, 1'b0, 10'd1020, 10'd50), 10'd1023, 10'd50, 1'b1, 16'd3});
    // 16-bit address wrap
    vecs.push_back('{mk_pat(16'hFFF0, 16'd16, 16'd16, 16'd16, 16'd16), s0, 10'd105, 10'd51, 1'b1, 16'd5});

    foreach (vecs[i]) begin
      drive(vecs[i].pat, vecs[i].spr, vecs[i].hc, vecs[i].vc);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea);
    end

    // Asynchronous reset mid-cycle with a hit registered
    drive(p0, s0, 10'd103, 10'd52);
    @(posedge clk); #1;
    chk("pre_async_reset", 1'b1, 16'd35);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_clear", 1'b0, 16'd0);
    @(posedge clk); #1;
    chk("reset_over_edge", 1'b0, 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_release_load", 1'b1, 16'd35);

    // Invisible sprite: full sweep of the box never hits
    for (int v = 50; v < 66; v++) begin
      for (int h = 100; h < 116; h++) begin
        drive(p0, mk_spr(1'b0, 1'b0, 10'd100, 10'd50), 10'(h), 10'(v));
        @(posedge clk); #1;
        chk($sformatf("invisible_%0d_%0d", h, v), 1'b0, 16'd0);
      end
    end

    // Latency: hcount 99 -> 100 -> 101 on row 50
    drive(p0, s0, 10'd99, 10'd50);
    @(posedge clk); #1;
    chk("lat_h99", 1'b0, 16'd0);
    drive(p0, s0, 10'd100, 10'd50);
    #1;
    chk("lat_not_combinational", 1'b0, 16'd0);
    @(posedge clk); #1;
    chk("lat_h100", 1'b1, 16'd0);
    drive(p0, s0, 10'd101, 10'd50);
    @(posedge clk); #1;
    chk("lat_h101", 1'b1, 16'd1);
    drive(p0, mk_spr(1'b0, 1'b0, 10'd100, 10'd50), 10'd102, 10'd50);
    @(posedge clk); #1;
    chk("lat_hide", 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_addr_cal.md
# sprite_addr_cal

Per-sprite pixel address generator for the on-chip sprite renderer. Each sprite display block instantiates one per child sprite and per ping/pong state buffer. From the sprite's pattern descriptor, its position/visibility word and the current VGA beam coordinate, it decides whether the beam is inside the sprite. When it is, it also computes the word address of the matching texel in the sprite pixel memory. Outputs are registered and feed the display block's priority mux and pixel-memory read.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock, one pixel per cycle.
- reset  input  1  asynchronous, active-high; clears all registered outputs.
- pattern_info  input  80  pattern descriptor, split as:
  - [79:64] base: pixel-memory address of texel (0,0).
  - [63:48] img_w: texels per row in memory.
  - [47:32] img_h: rows in memory.
  - [31:16] draw_w: on-screen box width.
  - [15:0] draw_h: on-screen box height.
- sprite_info  input  32  sprite state, split as:
  - [31] visible.
  - [30] hflip.
  - [29:20] x: left screen column.
  - [19:10] y: top screen row.
  - [9:0] reserved; ignored.
- hcount  input  10  current beam column.
- vcount  input  10  current beam row.
- addr_output  output  16  texel address; meaningful only when valid=1.
- valid  output  1  beam is on a drawable texel of a visible sprite.

## Operation
Compute intermediates combinationally each cycle:
- col = hcount − x; row = vcount − y.
  - Each is 10-bit unsigned, treated as out of range when hcount<x or vcount<y (no wrap into the box).
- in_box = visible AND x ≤ hcount < x+draw_w AND y ≤ vcount < y+draw_h.
  - Comparisons are done at 17 bits, so x+draw_w is never truncated.
- in_img = col < img_w AND row < img_h. This guards against descriptors whose draw box exceeds the image.
- tcol = hflip ? (img_w − 1 − col) : col.
- addr = base + row*img_w + tcol, computed modulo 2^16. The product uses the full width, then the sum is truncated to 16 bits.

Registered outputs, updated on every rising clk:
- valid ← in_box AND in_img.
- addr_output ← addr when in_box AND in_img.
- Otherwise addr_output ← 0. It is deterministic when invalid, to simplify checking.

Boundary cases:
- draw_w=0 or draw_h=0 → valid never asserts.
- img_w=0 → valid never asserts.
- x+draw_w > 639 → valid covers only columns the beam actually reaches; there is no wrap to column 0.
- The block has no state other than the output registers. Inputs may change any cycle; each output reflects the input sample of the previous edge.
- visible=0 forces valid=0 on the next edge regardless of other fields.

Reset:
- While reset=1: valid=0, addr_output=0.
- Asserting reset mid-line clears the outputs immediately (asynchronously).
- The first post-reset edge loads normally.

## Timing
- Latency is exactly 1 clk from hcount/vcount/pattern_info/sprite_info to valid/addr_output.
- No handshake. One result per cycle, full throughput.
- The display block compensates for the 1-cycle latency in its memory read pipeline.
- The multiply must close timing in a single cycle at the pixel clock (16×16 → 16 bits retained).

## Test plan
- Reset: assert reset with a visible sprite at beam position → valid=0, addr_output=0 immediately. Release, then one edge later outputs follow the inputs.
- Pattern {0,16,16,16,16}, sprite visible, x=100, y=50, no flip:
  - beam (100,50) → valid=1, addr=0.
  - beam (115,50) → addr=15.
  - beam (103,52) → addr=35.
  - beam (116,50) and (99,50) → valid=0.
  - beam (100,66) → valid=0.
- Pattern {256,16,8,16,8}, x=0, y=0:
  - beam (5,7) → addr=256+7*16+5=373.
  - beam (5,8) → valid=0.
- hflip=1 with pattern 0, x=100, y=50:
  - beam (100,50) → addr=15.
  - beam (115,51) → addr=16.
- visible=0 with beam inside the box → valid=0 for all positions in a full sweep of the box.
- Latency: step hcount 99→100→101 at y row → valid is 0,1,1 delayed by one cycle relative to the inputs. Addresses follow 0,1 one cycle after the inputs.
